// File: rtl/decim_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decim_pkg
// Purpose  : Shared types and helpers for the multirate decimator:
//            - decim_mode_e   : pick / accumulate-and-dump selector
//            - cnt_width()    : width of the frame counter and factor fields
//            - shift_width()  : width of the accumulate-mode shift field
//            - sat_clamp()    : clamp a wide signed value to a signed range
// Revision : 1.0 - initial release
// ============================================================================
package decim_pkg;

    typedef enum logic {
        DECIM_PICK = 1'b0,
        DECIM_ACC  = 1'b1
    } decim_mode_e;

    // Width able to hold every factor value 0..max_factor.
    function automatic int cnt_width(input int max_factor);
        return $clog2(max_factor + 1);
    endfunction

    // Width able to express any shift of the widest accumulator.
    function automatic int shift_width(input int cw, input int dw);
        return $clog2(cw + dw);
    endfunction

    // Clamp v to the signed range of a dw-bit two's complement number.
    // Callers detect saturation by comparing the result against v.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage : decim_pkg
`default_nettype wire

// File: rtl/decim_channel.sv
`default_nettype none
// ============================================================================
// Module   : decim_channel
// Purpose  : One decimator lane. Holds the accumulator / pick capture
//            register, the frame result register and the sticky
//            saturation flag for a single channel.
// Ports    : clk, rst_n     - clock, synchronous active-low reset
//            accept_i       - a sample is accepted this cycle
//            first_i        - current frame position is 0
//            pick_i         - current frame position equals the pick phase
//            last_i         - accepted sample closes the frame
//            mode_i         - pick or accumulate for the current frame
//            shift_i        - arithmetic right shift for accumulate results
//            din_i          - channel sample
//            dout_o         - registered frame result
//            sat_o          - sticky saturation indicator
// Revision : 1.0 - initial release
// ============================================================================
module decim_channel
    import decim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CW         = 5,
    parameter int SW         = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept_i,
    input  logic                  first_i,
    input  logic                  pick_i,
    input  logic                  last_i,
    input  decim_mode_e           mode_i,
    input  logic [SW-1:0]         shift_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  sat_o
);

    localparam int AW = DATA_WIDTH + CW;

    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   sat_q;

    logic signed [AW-1:0]   w_sample;
    logic signed [AW-1:0]   w_shifted;
    logic signed [63:0]     w_wide;
    logic signed [63:0]     w_clamped;
    logic                   w_hit;
    logic [DATA_WIDTH-1:0]  w_result;

    assign w_sample = {{CW{din_i[DATA_WIDTH-1]}}, din_i};

    // The register doubles as accumulator (ACC) and capture latch (PICK);
    // the mode is fixed for the whole frame so the two uses never mix.
    always_comb begin
        acc_d = acc_q;
        if (accept_i) begin
            if (mode_i == DECIM_ACC) begin
                acc_d = first_i ? w_sample : acc_q + w_sample;
            end else if (pick_i) begin
                acc_d = w_sample;
            end
        end
    end

    // The frame result is taken from acc_d so the closing sample is included
    // without an extra cycle of latency.
    assign w_shifted = acc_d >>> shift_i;
    assign w_wide    = {{(64 - AW){w_shifted[AW-1]}}, w_shifted};
    assign w_clamped = sat_clamp(w_wide, DATA_WIDTH);
    assign w_hit     = (w_clamped != w_wide);
    assign w_result  = (mode_i == DECIM_ACC) ? w_clamped[DATA_WIDTH-1:0]
                                             : acc_d[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (last_i) begin
                dout_q <= w_result;
                if ((mode_i == DECIM_ACC) && w_hit) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign dout_o = dout_q;
    assign sat_o  = sat_q;

endmodule : decim_channel
`default_nettype wire

// File: rtl/multirate_decimator.sv
`default_nettype none
// ============================================================================
// Module   : multirate_decimator
// Purpose  : NUM_CH lock-step channels decimated by a runtime factor M,
//            either keeping one sample per frame (pick) or summing the frame
//            (accumulate-and-dump, shifted and saturated). Valid/ready on
//            both sides with a single output register.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            cfg_factor/mode/phase/shift - frame configuration, sampled at
//                                          the first sample of each frame
//            in_valid/in_ready/in_data  - input sample vector handshake
//            out_valid/out_ready/out_data - decimated vector handshake
//            sat_flag                   - sticky per-channel saturation
// Revision : 1.0 - initial release
// ============================================================================
module multirate_decimator
    import decim_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 4,
    parameter  int MAX_FACTOR = 16,
    localparam int CW         = cnt_width(MAX_FACTOR),
    localparam int SW         = shift_width(CW, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CW-1:0]                cfg_factor,
    input  logic                         cfg_mode,
    input  logic [CW-1:0]                cfg_phase,
    input  logic [SW-1:0]                cfg_shift,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            sat_flag
);

    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           out_valid_q;
    logic           out_valid_d;
    logic [CW-1:0]  sh_factor_q;
    logic [CW-1:0]  sh_phase_q;
    decim_mode_e    sh_mode_q;
    logic [SW-1:0]  sh_shift_q;

    logic [CW-1:0]  w_live_factor;
    logic [CW-1:0]  w_live_phase;
    logic [CW-1:0]  w_factor;
    logic [CW-1:0]  w_phase;
    decim_mode_e    w_mode;
    logic [SW-1:0]  w_shift;
    logic           w_first;
    logic           w_accept;
    logic           w_last;
    logic           w_pick;

    // Sanitised view of the live configuration inputs.
    always_comb begin
        w_live_factor = cfg_factor;
        if (cfg_factor == '0) begin
            w_live_factor = CW'(1);
        end else if (cfg_factor > CW'(MAX_FACTOR)) begin
            w_live_factor = CW'(MAX_FACTOR);
        end
        w_live_phase = (cfg_phase >= w_live_factor) ? (w_live_factor - CW'(1))
                                                     : cfg_phase;
    end

    // At position 0 the frame is defined by the live inputs (they are being
    // latched on this very acceptance); afterwards the shadow copy rules.
    assign w_first  = (cnt_q == '0);
    assign w_factor = w_first ? w_live_factor : sh_factor_q;
    assign w_phase  = w_first ? w_live_phase  : sh_phase_q;
    assign w_mode   = w_first ? decim_mode_e'(cfg_mode) : sh_mode_q;
    assign w_shift  = w_first ? cfg_shift     : sh_shift_q;

    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (cnt_q == (w_factor - CW'(1)));
    assign w_pick   = (cnt_q == w_phase);

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept) begin
            cnt_d = w_last ? '0 : cnt_q + CW'(1);
        end
    end

    // A new result may land in the same cycle the old one is consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        if (w_last) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sh_factor_q <= CW'(1);
            sh_phase_q  <= '0;
            sh_mode_q   <= DECIM_PICK;
            sh_shift_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            if (w_accept && w_first) begin
                sh_factor_q <= w_live_factor;
                sh_phase_q  <= w_live_phase;
                sh_mode_q   <= decim_mode_e'(cfg_mode);
                sh_shift_q  <= cfg_shift;
            end
        end
    end

    assign out_valid = out_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        decim_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .CW         (CW),
            .SW         (SW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .accept_i (w_accept),
            .first_i  (w_first),
            .pick_i   (w_pick),
            .last_i   (w_last),
            .mode_i   (w_mode),
            .shift_i  (w_shift),
            .din_i    (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .dout_o   (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o    (sat_flag[g])
        );
    end

endmodule : multirate_decimator
`default_nettype wire
